// File: rtl/abs_window_mean_pkg.sv
// abs_window_mean_pkg: shared FSM encoding and accumulator width helper
package abs_window_mean_pkg;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int acc_width(input int width, input int log2_len);
        return width + log2_len;
    endfunction

endpackage

// File: rtl/abs_window_mean_abs_sat.sv
// abs_window_mean_abs_sat: registered absolute value of one channel, optional saturation of the most negative code
module abs_window_mean_abs_sat #(
    parameter int WIDTH = 16,
    parameter bit SAT   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vld,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] mag
);

    logic [WIDTH-1:0] abs_val;
    logic             is_min;

    assign is_min  = x == {1'b1, {(WIDTH-1){1'b0}}};
    assign abs_val = !x[WIDTH-1] ? x : (SAT && is_min) ? {1'b0, {(WIDTH-1){1'b1}}} : -x;

    // capture |x| on valid samples, zero otherwise
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) mag <= '0;
        else        mag <= vld ? abs_val : '0;

endmodule

// File: rtl/abs_window_mean.sv
// abs_window_mean: per-channel |x| plus mean magnitude over 2**LOG2_LEN valid samples
module abs_window_mean
    import abs_window_mean_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CH       = 2,
    parameter int LOG2_LEN = 6,
    parameter bit SAT      = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                vld,
    input  logic                clr,
    input  logic [CH*WIDTH-1:0] in,
    output logic [CH*WIDTH-1:0] mag,
    output logic                mag_vld,
    output logic [CH*WIDTH-1:0] mean,
    output logic                mean_vld,
    output logic                mean_ok
);

    localparam int ACC_W = acc_width(WIDTH, LOG2_LEN);

    state_t              state, state_next;
    logic [LOG2_LEN-1:0] cnt;
    logic                done;

    // a window completes on its last valid magnitude unless a clear takes priority
    assign done    = mag_vld && !clr && (cnt == '1);
    assign mean_ok = state == RUN;

    for (genvar k = 0; k < CH; k++) begin : g_ch
        logic [ACC_W-1:0] acc, sum;
        logic [WIDTH-1:0] mean_r;

        abs_window_mean_abs_sat #(.WIDTH(WIDTH), .SAT(SAT)) u_abs (
            .clk   (clk),
            .rst_n (rst_n),
            .vld   (vld),
            .x     (in[k*WIDTH +: WIDTH]),
            .mag   (mag[k*WIDTH +: WIDTH])
        );

        assign sum                   = acc + ACC_W'(mag[k*WIDTH +: WIDTH]);
        assign mean[k*WIDTH +: WIDTH] = mean_r;

        // accumulate magnitudes; the top WIDTH bits of the final sum are the floored mean
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                acc    <= '0;
                mean_r <= '0;
            end else if (clr) begin
                acc <= '0;
            end else if (mag_vld) begin
                acc <= done ? '0 : sum;
                if (done) mean_r <= sum[ACC_W-1 -: WIDTH];
            end
    end

    // shared valid pipeline and window sample counter (wraps at window end)
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            mag_vld  <= 1'b0;
            mean_vld <= 1'b0;
            cnt      <= '0;
        end else begin
            mag_vld  <= vld;
            mean_vld <= done;
            cnt      <= clr ? '0 : mag_vld ? cnt + 1'b1 : cnt;
        end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= FILL;
        else        state <= state_next;

    // FILL until the first completed window; clear always returns to FILL
    always_comb begin
        state_next = state;
        state_next = clr ? FILL : done ? RUN : state;
    end

endmodule

// File: tb/tb_abs_window_mean.sv
// tb_abs_window_mean: directed checks of abs/saturation, windowed mean, gaps, clear and async reset
module tb_abs_window_mean;

    localparam int W  = 16;
    localparam int CH = 2;

    logic          clk = 1'b0, rst_n = 1'b1, vld = 1'b0, clr = 1'b0;
    logic [CH*W-1:0] in = '0;
    logic [CH*W-1:0] mag, mean, mag_w, mean_w;
    logic          mag_vld, mean_vld, mean_ok, mag_vld_w, mean_vld_w, mean_ok_w;
    int            checks = 0, errors = 0;

    always #5 clk = ~clk;

    abs_window_mean #(.WIDTH(W), .CH(CH), .LOG2_LEN(2), .SAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .vld(vld), .clr(clr), .in(in),
        .mag(mag), .mag_vld(mag_vld), .mean(mean), .mean_vld(mean_vld), .mean_ok(mean_ok)
    );

    abs_window_mean #(.WIDTH(W), .CH(CH), .LOG2_LEN(2), .SAT(0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .vld(vld), .clr(clr), .in(in),
        .mag(mag_w), .mag_vld(mag_vld_w), .mean(mean_w), .mean_vld(mean_vld_w), .mean_ok(mean_ok_w)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] c1, input logic [15:0] c0);
        vld = v;
        in  = {c1, c0};
    endtask

    task automatic do_reset();
        vld = 1'b0; clr = 1'b0; in = '0;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++; if (mag !== '0 || mag_vld !== 1'b0) begin errors++; $display("FAIL reset_mag: mag=%h vld=%b required 0/0", mag, mag_vld); end
        checks++; if (mean !== '0 || mean_vld !== 1'b0 || mean_ok !== 1'b0) begin errors++; $display("FAIL reset_mean: mean=%h vld=%b ok=%b required 0/0/0", mean, mean_vld, mean_ok); end
        #9 rst_n = 1'b1;
        step();
    endtask

    task automatic test_abs();
        drive(1'b1, 16'd7, 16'hFFFB);
        step();
        checks++; if (mag !== {16'd7, 16'd5} || mag_vld !== 1'b1) begin errors++; $display("FAIL abs_basic: mag=%h vld=%b required 00070005/1", mag, mag_vld); end
        drive(1'b1, 16'h8001, 16'hFFFF);
        step();
        checks++; if (mag !== {16'h7FFF, 16'd1}) begin errors++; $display("FAIL abs_edge: mag=%h required 7fff0001", mag); end
        drive(1'b0, 16'd7, 16'hFFFB);
        step();
        checks++; if (mag !== '0 || mag_vld !== 1'b0) begin errors++; $display("FAIL abs_idle: mag=%h vld=%b required 0/0", mag, mag_vld); end
    endtask

    task automatic test_sat();
        drive(1'b1, 16'h7FFF, 16'h8000);
        step();
        checks++; if (mag !== {16'h7FFF, 16'h7FFF}) begin errors++; $display("FAIL sat_on: mag=%h required 7fff7fff", mag); end
        checks++; if (mag_w !== {16'h7FFF, 16'h8000}) begin errors++; $display("FAIL sat_off: mag=%h required 7fff8000", mag_w); end
        drive(1'b0, 16'd0, 16'd0);
        step();
    endtask

    task automatic test_window();
        logic [15:0] c0 [4] = '{16'hFFFC, 16'd4, 16'hFFF8, 16'd8};
        logic [15:0] c1 [4] = '{16'd1, 16'd2, 16'd3, 16'd7};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, c1[i], c0[i]);
            step();
            checks++; if (mean_vld !== 1'b0 || mean_ok !== 1'b0) begin errors++; $display("FAIL win_early%0d: mean_vld=%b ok=%b required 0/0", i, mean_vld, mean_ok); end
        end
        drive(1'b0, 16'd0, 16'd0);
        step();
        checks++; if (mean_vld !== 1'b1 || mean !== {16'd3, 16'd6}) begin errors++; $display("FAIL win_mean: vld=%b mean=%h required 1/00030006", mean_vld, mean); end
        checks++; if (mean_ok !== 1'b1) begin errors++; $display("FAIL win_ok: mean_ok=%b required 1", mean_ok); end
        checks++; if (mean_w !== {16'd3, 16'd6}) begin errors++; $display("FAIL win_mean_nosat: mean=%h required 00030006", mean_w); end
        step();
        checks++; if (mean_vld !== 1'b0 || mean !== {16'd3, 16'd6}) begin errors++; $display("FAIL win_hold: vld=%b mean=%h required 0/00030006", mean_vld, mean); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'hFFF7, 16'd2);
            step();
        end
        drive(1'b0, 16'd0, 16'd0);
        step();
        checks++; if (mean_vld !== 1'b1 || mean !== {16'd9, 16'd2}) begin errors++; $display("FAIL win_restart: vld=%b mean=%h required 1/00090002", mean_vld, mean); end
    endtask

    task automatic test_gaps();
        logic [15:0] c0 [4] = '{16'hFFFC, 16'd4, 16'hFFF8, 16'd8};
        logic [15:0] c1 [4] = '{16'd1, 16'd2, 16'd3, 16'd7};
        logic [15:0] m0 [4] = '{16'd4, 16'd4, 16'd8, 16'd8};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, c1[i], c0[i]);
            step();
            checks++; if (mag !== {c1[i], m0[i]} || mag_vld !== 1'b1) begin errors++; $display("FAIL gap_mag%0d: mag=%h vld=%b required %h/1", i, mag, mag_vld, {c1[i], m0[i]}); end
            drive(1'b0, 16'd0, 16'd0);
            for (int g = 0; g < 3; g++) begin
                step();
                checks++; if (mag !== '0 || mag_vld !== 1'b0) begin errors++; $display("FAIL gap_idle%0d_%0d: mag=%h vld=%b required 0/0", i, g, mag, mag_vld); end
                checks++; if (mean_vld !== (i == 3 && g == 0)) begin errors++; $display("FAIL gap_pulse%0d_%0d: mean_vld=%b required %b", i, g, mean_vld, i == 3 && g == 0); end
            end
        end
        checks++; if (mean !== {16'd3, 16'd6} || mean_ok !== 1'b1) begin errors++; $display("FAIL gap_mean: mean=%h ok=%b required 00030006/1", mean, mean_ok); end
    endtask

    task automatic test_clr();
        checks++; if (mean_ok !== 1'b1) begin errors++; $display("FAIL clr_pre_ok: mean_ok=%b required 1", mean_ok); end
        drive(1'b1, 16'd50, 16'd100);
        step();
        step();
        clr = 1'b1;
        drive(1'b1, 16'd20, 16'd10);
        step();
        clr = 1'b0;
        checks++; if (mean_ok !== 1'b0 || mean_vld !== 1'b0) begin errors++; $display("FAIL clr_state: ok=%b mean_vld=%b required 0/0", mean_ok, mean_vld); end
        checks++; if (mean !== {16'd3, 16'd6}) begin errors++; $display("FAIL clr_hold: mean=%h required 00030006", mean); end
        checks++; if (mag !== {16'd20, 16'd10} || mag_vld !== 1'b1) begin errors++; $display("FAIL clr_stage1: mag=%h vld=%b required 0014000a/1", mag, mag_vld); end
        for (int i = 1; i < 4; i++) begin
            step();
            checks++; if (mean_vld !== 1'b0 || mean_ok !== 1'b0) begin errors++; $display("FAIL clr_early%0d: mean_vld=%b ok=%b required 0/0", i, mean_vld, mean_ok); end
        end
        drive(1'b0, 16'd0, 16'd0);
        step();
        checks++; if (mean_vld !== 1'b1 || mean !== {16'd20, 16'd10} || mean_ok !== 1'b1) begin errors++; $display("FAIL clr_mean: vld=%b mean=%h ok=%b required 1/0014000a/1", mean_vld, mean, mean_ok); end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 16'd5, 16'd5);
        step();
        step();
        drive(1'b0, 16'd0, 16'd0);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mag !== '0 || mag_vld !== 1'b0) begin errors++; $display("FAIL async_mag: mag=%h vld=%b required 0/0", mag, mag_vld); end
        checks++; if (mean !== '0 || mean_vld !== 1'b0 || mean_ok !== 1'b0) begin errors++; $display("FAIL async_mean: mean=%h vld=%b ok=%b required 0/0/0", mean, mean_vld, mean_ok); end
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'd3, 16'hFFF4);
            step();
            checks++; if (mag !== {16'd3, 16'd12} || mean_vld !== 1'b0) begin errors++; $display("FAIL async_fill%0d: mag=%h mean_vld=%b required 0003000c/0", i, mag, mean_vld); end
        end
        drive(1'b0, 16'd0, 16'd0);
        step();
        checks++; if (mean_vld !== 1'b1 || mean !== {16'd3, 16'd12} || mean_ok !== 1'b1) begin errors++; $display("FAIL async_mean_after: vld=%b mean=%h ok=%b required 1/0003000c/1", mean_vld, mean, mean_ok); end
    endtask

    initial begin
        test_reset();
        test_abs();
        test_sat();
        test_window();
        test_gaps();
        test_clr();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
